blink_sequencer: RTL

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

---
 rtl/blink_pkg.sv | 31 +++
 rtl/half_period_tick.sv | 31 +++
 rtl/blink_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared types and helpers for the blink sequencer.
// HALF is derived from the clock and blink frequencies via HalfCycles.
package blink_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_PAUSE,
    S_DONE
  } state_t;

  function automatic int CeilLog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int HalfCycles(input int base, input int tgt);
    return base / (2 * tgt);
  endfunction

  // Terminal count of a HALF-cycle counter starting at zero
  function automatic int CountValue(input int half);
    return half - 1;
  endfunction

endpackage

// File: rtl/half_period_tick.sv
// Free-running half-period counter with synchronous clear.
// o_tick pulses on the last cycle of every HALF-cycle window.
module half_period_tick
  import blink_pkg::*;
#(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = CeilLog2(HALF);
  localparam logic [CW-1:0] TC = CW'(CountValue(HALF));

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == TC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/blink_sequencer.sv
// LED blink sequencer: blinkCount ON/OFF cycles of HALF clocks each.
// Define BLINK_REPEAT_EN to add the repeatEn input and PAUSE looping.
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int BASE_CLK         = 50000000,
  parameter int TARGET_FREQUENCY = 1,
  parameter int NBITS_BLINK      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [NBITS_BLINK-1:0] blinkCount,
`ifdef BLINK_REPEAT_EN
  input  logic                   repeatEn,
`endif
  output logic                   ledOut,
  output logic                   busy,
  output logic                   done
);

  localparam int HALF = HalfCycles(BASE_CLK, TARGET_FREQUENCY);

  if (HALF < 2) begin : g_half_chk
    $error("blink_sequencer: HALF must be at least 2");
  end

  state_t                 r_state;
  state_t                 w_next;
  logic [NBITS_BLINK-1:0] r_remain;
  logic                   r_led;
  logic                   w_tick;
  logic                   w_clear;
  logic                   w_last;

`ifdef BLINK_REPEAT_EN
  logic [NBITS_BLINK-1:0] r_latched;
  logic                   r_pause2;
`endif

  assign w_last  = (r_remain == NBITS_BLINK'(1));
  assign w_clear = (w_next != r_state) || (r_state == S_IDLE);

  half_period_tick #(
    .HALF(HALF)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clear(w_clear),
    .o_tick (w_tick)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_next = (blinkCount == '0) ? S_DONE : S_ON;
        end
      end
      S_ON: begin
        if (w_tick) w_next = S_OFF;
      end
      S_OFF: begin
        if (w_tick) begin
          if (!w_last) begin
            w_next = S_ON;
          end else begin
`ifdef BLINK_REPEAT_EN
            w_next = repeatEn ? S_PAUSE : S_DONE;
`else
            w_next = S_DONE;
`endif
          end
        end
      end
      S_PAUSE: begin
`ifdef BLINK_REPEAT_EN
        if (w_tick && r_pause2) w_next = S_ON;
`else
        w_next = S_IDLE;
`endif
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort wins over any phase transition
    if (stop && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_remain <= '0;
      r_led    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_led   <= (w_next == S_ON);
      if (r_state == S_IDLE && w_next == S_ON) begin
        r_remain <= blinkCount;
      end else if (r_state == S_OFF && w_tick && !stop) begin
        r_remain <= r_remain - NBITS_BLINK'(1);
`ifdef BLINK_REPEAT_EN
      end else if (r_state == S_PAUSE && w_next == S_ON) begin
        r_remain <= r_latched;
`endif
      end
    end
  end

`ifdef BLINK_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_latched <= '0;
      r_pause2  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_next == S_ON) r_latched <= blinkCount;
      if (r_state != S_PAUSE) r_pause2 <= 1'b0;
      else if (w_tick)        r_pause2 <= 1'b1;
    end
  end
`endif

  assign ledOut = r_led;
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);

endmodule
